// File: rtl/axi_lite_reg_master_if.sv
// Command/response port plus AXI4-Lite channels for axi_lite_reg_master.
// The master modport is the initiator's view; slave is the environment's.
interface axi_lite_reg_master_if #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 32
) ();
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_wr;
    logic [AddrWidth-1:0]     cmd_addr;
    logic [DataWidth-1:0]     cmd_wdata;
    logic [DataWidth/8-1:0]   cmd_wstrb;

    logic                     rsp_valid;
    logic [DataWidth-1:0]     rsp_rdata;
    logic                     rsp_err;
    logic                     rsp_timeout;

    logic [AddrWidth-1:0]     m_axi_awaddr;
    logic [2:0]               m_axi_awprot;
    logic                     m_axi_awvalid;
    logic                     m_axi_awready;
    logic [DataWidth-1:0]     m_axi_wdata;
    logic [DataWidth/8-1:0]   m_axi_wstrb;
    logic                     m_axi_wvalid;
    logic                     m_axi_wready;
    logic [1:0]               m_axi_bresp;
    logic                     m_axi_bvalid;
    logic                     m_axi_bready;
    logic [AddrWidth-1:0]     m_axi_araddr;
    logic [2:0]               m_axi_arprot;
    logic                     m_axi_arvalid;
    logic                     m_axi_arready;
    logic [DataWidth-1:0]     m_axi_rdata;
    logic [1:0]               m_axi_rresp;
    logic                     m_axi_rvalid;
    logic                     m_axi_rready;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_lite_reg_master.sv
// Single-beat AXI4-Lite initiator: one outstanding read or write per command,
// fully registered AXI outputs and a per-transaction wait-cycle timeout.
module axi_lite_reg_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                       board_clk,
    input  logic                       reset,
    axi_lite_reg_master_if.master      bus
);
    localparam int unsigned StrbWidth = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [15:0] TmoLimit  = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle, StWr, StWrResp, StRdAddr, StRdData, StResp
    } state_e;

    state_e                          state_q, state_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]            wstrb_q, wstrb_d;
    logic [15:0]                     tmo_cnt_q, tmo_cnt_d;
    logic                            tmo_hit;
    logic                            rsp_valid_q, rsp_valid_d;
    logic                            rsp_err_q, rsp_err_d;
    logic                            rsp_timeout_q, rsp_timeout_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        tmo_cnt_d     = tmo_cnt_q;
        tmo_hit       = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;

        // The counter only runs while waiting on the slave.
        if (state_q inside {StWr, StWrResp, StRdAddr, StRdData}) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
            tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt_d == TmoLimit);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d    = bus.cmd_addr;
                    wdata_d   = bus.cmd_wdata;
                    wstrb_d   = bus.cmd_wstrb;
                    tmo_cnt_d = '0;
                    if (bus.cmd_wr) begin
                        state_d   = StWr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdAddr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWr: begin
                if (awvalid_q && bus.m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (bready_q && bus.m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (bus.m_axi_bresp != 2'b00);
                    rsp_rdata_d = '0;
                end
            end
            StRdAddr: begin
                if (arvalid_q && bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (rready_q && bus.m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (bus.m_axi_rresp != 2'b00);
                    rsp_rdata_d = bus.m_axi_rdata;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort wins over a handshake landing on the same edge; the slave needs a reset anyway.
        if (tmo_hit) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            state_d       = StResp;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
        end

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            tmo_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Bench for axi_lite_reg_master: delay-programmable AXI4-Lite slave plus a
// word-array reference model predicting read data, latency and error flags.
module tb_axi_lite_reg_master;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned Tmo = 16;

    logic board_clk = 1'b0;
    logic reset     = 1'b1;
    always #5 board_clk = ~board_clk;

    axi_lite_reg_master_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    axi_lite_reg_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .board_clk(board_clk),
        .reset(reset),
        .bus(bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Slave behaviour knobs, set by the stimulus
    int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic        ar_block;
    logic [1:0]  b_resp_k, r_resp_k;
    logic        r_ovr;
    logic [31:0] r_ovr_data;

    // Slave state
    logic [31:0] mem [64];
    logic        aw_got, w_got, b_pend, ar_got;
    int unsigned aw_wait, w_wait, b_cnt, ar_wait, r_cnt;
    logic [7:0]  aw_addr_l, ar_addr_l;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data, wr_old, wr_merged;
    logic [3:0]  wr_strb;

    // Event counters observed at clock edges
    int unsigned aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs_n = 0, rsp_n = 0;

    logic [31:0] model [64];

    assign bus.m_axi_awready = !aw_got && (aw_wait >= aw_dly);
    assign bus.m_axi_wready  = !w_got && (w_wait >= w_dly);
    assign bus.m_axi_bvalid  = b_pend && (b_cnt >= b_dly);
    assign bus.m_axi_bresp   = b_resp_k;
    assign bus.m_axi_arready = !ar_got && !ar_block && (ar_wait >= ar_dly);
    assign bus.m_axi_rvalid  = ar_got && (r_cnt >= r_dly);
    assign bus.m_axi_rresp   = r_resp_k;
    assign bus.m_axi_rdata   = r_ovr ? r_ovr_data : mem[ar_addr_l[7:2]];

    assign aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
    assign w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
    assign b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;
    assign ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
    assign r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;

    assign wr_addr = aw_got ? aw_addr_l : bus.m_axi_awaddr;
    assign wr_data = w_got ? w_data_l : bus.m_axi_wdata;
    assign wr_strb = w_got ? w_strb_l : bus.m_axi_wstrb;
    assign wr_old  = mem[wr_addr[7:2]];
    assign wr_merged = {wr_strb[3] ? wr_data[31:24] : wr_old[31:24],
                        wr_strb[2] ? wr_data[23:16] : wr_old[23:16],
                        wr_strb[1] ? wr_data[15:8]  : wr_old[15:8],
                        wr_strb[0] ? wr_data[7:0]   : wr_old[7:0]};

    always @(posedge board_clk) begin
        if (reset) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; ar_got <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_cnt <= 0; ar_wait <= 0; r_cnt <= 0;
            aw_addr_l <= '0; ar_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1; aw_addr_l <= bus.m_axi_awaddr; aw_wait <= 0;
            end else if (bus.m_axi_awvalid && !aw_got) begin
                aw_wait <= aw_wait + 1;
            end
            if (w_hs) begin
                w_got <= 1'b1; w_data_l <= bus.m_axi_wdata; w_strb_l <= bus.m_axi_wstrb;
                w_wait <= 0;
            end else if (bus.m_axi_wvalid && !w_got) begin
                w_wait <= w_wait + 1;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
                b_pend <= 1'b1; b_cnt <= 0;
                mem[wr_addr[7:2]] <= wr_merged;
            end else if (b_pend && !bus.m_axi_bvalid) begin
                b_cnt <= b_cnt + 1;
            end
            if (b_hs) begin
                b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (ar_hs) begin
                ar_got <= 1'b1; ar_addr_l <= bus.m_axi_araddr; ar_wait <= 0; r_cnt <= 0;
            end else if (bus.m_axi_arvalid && !ar_got) begin
                ar_wait <= ar_wait + 1;
            end
            if (ar_got && !bus.m_axi_rvalid) r_cnt <= r_cnt + 1;
            if (r_hs) ar_got <= 1'b0;
        end
    end

    always @(posedge board_clk) begin
        if (bus.m_axi_awvalid) aw_hi <= aw_hi + 1;
        if (bus.m_axi_wvalid)  w_hi  <= w_hi + 1;
        if (bus.m_axi_arvalid) ar_hi <= ar_hi + 1;
        if (b_hs)              b_hs_n <= b_hs_n + 1;
        if (bus.rsp_valid)     rsp_n <= rsp_n + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = '0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) model[a[7:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    // Issues one command from a negedge and returns at the negedge where rsp_valid is seen.
    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, output logic [31:0] rd, output logic err,
                           output logic tmo, output int lat);
        int  waitn = 0;
        logic leak = 1'b0;
        lat = -1; rd = '0; err = 1'b0; tmo = 1'b0;
        while (!bus.cmd_ready && waitn < 50) begin
            @(negedge board_clk);
            waitn++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
            return;
        end
        bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = wd; bus.cmd_wstrb = ws;
        @(negedge board_clk);
        for (int n = 1; n <= 80; n++) begin
            if (bus.rsp_valid) begin
                lat = n; rd = bus.rsp_rdata; err = bus.rsp_err; tmo = bus.rsp_timeout;
                break;
            end
            if (bus.cmd_ready) leak = 1'b1;
            // Junk command traffic while busy must be ignored
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_wr    = 1'($urandom_range(0, 1));
            bus.cmd_addr  = 8'($urandom);
            bus.cmd_wdata = $urandom;
            bus.cmd_wstrb = 4'($urandom);
            @(negedge board_clk);
        end
        bus.cmd_valid = 1'b0;
        if (lat < 0) chk("rsp_wait_bound", 64'(bus.rsp_valid), 64'd1);
        if (leak) chk("cmd_ready_while_busy", 64'(leak), 64'd0);
    endtask

    logic [31:0] rd;
    logic        err, tmo;
    int          lat;
    int unsigned s_aw, s_w, s_ar, s_b, s_rsp;
    int unsigned mx;
    logic        wr_r;
    logic [7:0]  a_r;
    logic [31:0] d_r;
    logic [3:0]  s_r;

    initial begin
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; ar_block = 1'b0;
        b_resp_k = 2'b00; r_resp_k = 2'b00; r_ovr = 1'b0; r_ovr_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
        model_clear();

        reset = 1'b1;
        repeat (3) @(negedge board_clk);
        chk("reset_ctrl", 64'({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid,
                               bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready,
                               bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}), 64'd0);
        chk("reset_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("prot", 64'({bus.m_axi_awprot, bus.m_axi_arprot}), 64'd0);
        reset = 1'b0;
        @(negedge board_clk);
        chk("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        // Zero-wait write
        s_aw = aw_hi; s_w = w_hi;
        run_cmd(1'b1, 8'h08, 32'hDEADBEEF, 4'hF, rd, err, tmo, lat);
        model_write(8'h08, 32'hDEADBEEF, 4'hF);
        chk("zw_write_lat", 64'(lat), 64'd3);
        chk("zw_write_flags", 64'({err, tmo}), 64'd0);
        chk("zw_write_rdata", 64'(rd), 64'd0);
        chk("zw_write_same_cycle", 64'({aw_hi - s_aw, w_hi - s_w}), {32'd1, 32'd1});
        chk("zw_write_mem", 64'(mem[2]), 64'(model[2]));

        // Zero-wait read back, then rdata must hold
        run_cmd(1'b0, 8'h08, 32'h0, 4'h0, rd, err, tmo, lat);
        chk("zw_read_lat", 64'(lat), 64'd3);
        chk("zw_read_data", 64'(rd), 64'(model[2]));
        chk("zw_read_err", 64'(err), 64'd0);
        repeat (3) @(negedge board_clk);
        chk("rdata_hold", 64'(bus.rsp_rdata), 64'(model[2]));

        // Skewed write: AWREADY late by 3 cycles
        aw_dly = 3;
        s_aw = aw_hi; s_w = w_hi; s_b = b_hs_n; s_rsp = rsp_n;
        run_cmd(1'b1, 8'h10, 32'hCAFEF00D, 4'hF, rd, err, tmo, lat);
        model_write(8'h10, 32'hCAFEF00D, 4'hF);
        chk("skew_lat", 64'(lat), 64'd6);
        chk("skew_wvalid_cycles", 64'(w_hi - s_w), 64'd1);
        chk("skew_awvalid_cycles", 64'(aw_hi - s_aw), 64'd4);
        repeat (3) @(negedge board_clk);
        chk("skew_b_handshakes", 64'(b_hs_n - s_b), 64'd1);
        chk("skew_rsp_pulses", 64'(rsp_n - s_rsp), 64'd1);
        aw_dly = 0;

        // SLVERR read
        r_resp_k = 2'b10; r_ovr = 1'b1; r_ovr_data = 32'h12345678;
        run_cmd(1'b0, 8'h10, 32'h0, 4'h0, rd, err, tmo, lat);
        chk("slverr_flags", 64'({err, tmo}), 64'b10);
        chk("slverr_rdata", 64'(rd), 64'h12345678);
        r_resp_k = 2'b00; r_ovr = 1'b0;

        // Timeout with ARREADY held low
        ar_block = 1'b1;
        s_ar = ar_hi;
        run_cmd(1'b0, 8'h04, 32'h0, 4'h0, rd, err, tmo, lat);
        chk("tmo_lat", 64'(lat), 64'(Tmo + 1));
        chk("tmo_flags", 64'({err, tmo}), 64'b11);
        chk("tmo_rdata", 64'(rd), 64'd0);
        chk("tmo_arvalid_low", 64'(bus.m_axi_arvalid), 64'd0);
        chk("tmo_arvalid_cycles", 64'(ar_hi - s_ar), 64'(Tmo));
        ar_block = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge board_clk);
        reset = 1'b0;
        model_clear();
        @(negedge board_clk);

        // Reset while waiting for the write response
        b_dly = 10;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 8'h20;
        bus.cmd_wdata = 32'hA5A55A5A; bus.cmd_wstrb = 4'hF;
        @(negedge board_clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.m_axi_bready; i++) @(negedge board_clk);
        chk("midop_in_wr_resp", 64'(bus.m_axi_bready), 64'd1);
        s_rsp = rsp_n;
        reset = 1'b1;
        @(negedge board_clk);
        chk("midop_outputs", 64'({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid,
                                  bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready,
                                  bus.rsp_valid}), 64'd0);
        reset = 1'b0;
        model_clear();
        b_dly = 0;
        @(negedge board_clk);
        chk("midop_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        repeat (2) @(negedge board_clk);
        chk("midop_no_rsp", 64'(rsp_n - s_rsp), 64'd0);
        run_cmd(1'b0, 8'h20, 32'h0, 4'h0, rd, err, tmo, lat);
        chk("midop_read_lat", 64'(lat), 64'd3);
        chk("midop_read_data", 64'({err, tmo, rd}), 64'({2'b00, model[8]}));

        // Randomized traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            b_resp_k = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_resp_k = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            wr_r = 1'($urandom_range(0, 1));
            a_r  = 8'($urandom);
            d_r  = $urandom;
            s_r  = 4'($urandom);
            run_cmd(wr_r, a_r, d_r, s_r, rd, err, tmo, lat);
            if (wr_r) begin
                model_write(a_r, d_r, s_r);
                mx = (aw_dly > w_dly) ? aw_dly : w_dly;
                chk("rnd_wr_lat", 64'(lat), 64'(3 + mx + b_dly));
                chk("rnd_wr_resp", 64'({err, tmo, rd}), 64'({b_resp_k != 2'b00, 1'b0, 32'h0}));
            end else begin
                chk("rnd_rd_lat", 64'(lat), 64'(3 + ar_dly + r_dly));
                chk("rnd_rd_resp", 64'({err, tmo, rd}),
                    64'({r_resp_k != 2'b00, 1'b0, model[a_r[7:2]]}));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
